// File: rtl/fetch_if.sv
// Instruction-memory request/ack bus between fetch and imem.
// master: fetch side (req/addr out, ack/data in); slave: memory side.
interface fetch_if #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32
);
  logic                f_o_imem_req;
  logic [PC_WIDTH-1:0] f_o_imem_addr;
  logic                f_i_imem_ack;
  logic [IWIDTH-1:0]   f_i_imem_data;

  modport master (
    output f_o_imem_req,
    output f_o_imem_addr,
    input  f_i_imem_ack,
    input  f_i_imem_data
  );

  modport slave (
    input  f_o_imem_req,
    input  f_o_imem_addr,
    output f_i_imem_ack,
    output f_i_imem_data
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: sequential PC, one-entry skid, redirect/flush.
// Ports: f_clk/f_rst, decoder stall/flush, redirect, imem bus, decoder outs.
module fetch #(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IWIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                f_clk,
  input  logic                f_rst,
  input  logic                f_i_stall,
  input  logic                f_i_flush,
  input  logic                f_i_change_pc,
  input  logic [PC_WIDTH-1:0] f_i_new_pc,
  fetch_if.master             imem,
  output logic [IWIDTH-1:0]   f_o_instr,
  output logic [PC_WIDTH-1:0] f_o_pc,
  output logic                f_o_ce
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_t;

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(4);

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [IWIDTH-1:0]   skid_instr;
  logic [PC_WIDTH-1:0] tgt;
  logic                ack;
  logic                unused_lsb;

  assign tgt        = {f_i_new_pc[PC_WIDTH-1:2], 2'b00};
  assign unused_lsb = ^f_i_new_pc[1:0];
  assign ack        = imem.f_i_imem_ack;

  assign imem.f_o_imem_req  = (state == REQ);
  assign imem.f_o_imem_addr = pc;

  always_ff @(posedge f_clk or posedge f_rst) begin
    if (f_rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      skid_pc    <= '0;
      skid_instr <= '0;
      f_o_instr  <= '0;
      f_o_pc     <= '0;
      f_o_ce     <= 1'b0;
    end else if (f_i_change_pc) begin
      pc     <= tgt;
      f_o_ce <= 1'b0;
      unique case (state)
        // an unanswered request must have its ack swallowed
        REQ:     state <= ack ? REQ : DROP;
        DROP:    state <= ack ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else if (f_i_flush) begin
      f_o_ce <= 1'b0;
      unique case (state)
        REQ: if (ack) pc <= pc + STEP;
        DROP: if (ack) state <= REQ;
        default: state <= REQ;
      endcase
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (ack) begin
            pc <= pc + STEP;
            if (f_i_stall) begin
              skid_instr <= imem.f_i_imem_data;
              skid_pc    <= pc;
              state      <= HOLD;
            end else begin
              f_o_instr <= imem.f_i_imem_data;
              f_o_pc    <= pc;
              f_o_ce    <= 1'b1;
            end
          end else if (!f_i_stall) begin
            f_o_ce <= 1'b0;
          end
        end
        HOLD: begin
          if (!f_i_stall) begin
            f_o_instr <= skid_instr;
            f_o_pc    <= skid_pc;
            f_o_ce    <= 1'b1;
            state     <= REQ;
          end
        end
        DROP: if (ack) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_fetch;

  localparam int          PW = 32;
  localparam int          IW = 32;
  localparam logic [31:0] RPC = 32'h0;

  logic          f_clk;
  logic          f_rst;
  logic          f_i_stall;
  logic          f_i_flush;
  logic          f_i_change_pc;
  logic [PW-1:0] f_i_new_pc;
  logic [IW-1:0] f_o_instr;
  logic [PW-1:0] f_o_pc;
  logic          f_o_ce;

  fetch_if #(.PC_WIDTH(PW), .IWIDTH(IW)) bus ();

  fetch #(
    .PC_WIDTH(PW),
    .IWIDTH  (IW),
    .RESET_PC(RPC)
  ) dut (
    .f_clk        (f_clk),
    .f_rst        (f_rst),
    .f_i_stall    (f_i_stall),
    .f_i_flush    (f_i_flush),
    .f_i_change_pc(f_i_change_pc),
    .f_i_new_pc   (f_i_new_pc),
    .imem         (bus.master),
    .f_o_instr    (f_o_instr),
    .f_o_pc       (f_o_pc),
    .f_o_ce       (f_o_ce)
  );

  initial f_clk = 1'b0;
  always #5 f_clk = ~f_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: fetch pointer, pending-output queue, ack-to-drop flag
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_drop;
  logic [63:0] m_buf[$];
  logic        m_ce;
  logic [31:0] m_instr;
  logic [31:0] m_opc;
  bit          mem_pend;
  logic [31:0] mem_addr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a * 32'd7 + 32'h13;
  endfunction

  function automatic bit m_req();
    return m_started && (m_buf.size() == 0) && !m_drop;
  endfunction

  task automatic m_reset();
    m_pc      = RPC;
    m_started = 0;
    m_drop    = 0;
    m_buf.delete();
    m_ce      = 0;
    m_instr   = '0;
    m_opc     = '0;
    mem_pend  = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("req", 64'(bus.f_o_imem_req), 64'(m_req()));
    chk("addr", 64'(bus.f_o_imem_addr), 64'(m_pc));
    chk("ce", 64'(f_o_ce), 64'(m_ce));
    chk("instr", 64'(f_o_instr), 64'(m_instr));
    chk("opc", 64'(f_o_pc), 64'(m_opc));
  endtask

  // one clock: check, drive inputs, advance model, cross posedge
  task automatic step(input bit stall, input bit flush, input bit chg,
                      input logic [31:0] npc, input bit ack_en);
    bit          r;
    bit          a;
    logic [31:0] tgt;
    check_all();
    r   = m_req();
    a   = (r || mem_pend) && ack_en;
    tgt = {npc[31:2], 2'b00};
    f_i_stall     = stall;
    f_i_flush     = flush;
    f_i_change_pc = chg;
    f_i_new_pc    = npc;
    bus.f_i_imem_ack  = a;
    bus.f_i_imem_data = a ? memfn(r ? bus.f_o_imem_addr : mem_addr) : '0;
    if (!m_started) begin
      m_started = 1;
      if (chg) m_pc = tgt;
    end else if (chg) begin
      m_ce = 0;
      m_buf.delete();
      if (m_drop) m_drop = !a;
      else if (r && !a) m_drop = 1;
      m_pc = tgt;
    end else if (flush) begin
      m_ce = 0;
      m_buf.delete();
      if (r && a) m_pc = m_pc + 4;
      if (m_drop && a) m_drop = 0;
    end else if (m_drop) begin
      if (a) m_drop = 0;
    end else if (m_buf.size() != 0) begin
      if (!stall) begin
        {m_opc, m_instr} = m_buf.pop_front();
        m_ce = 1;
      end
    end else if (a) begin
      if (stall) m_buf.push_back({m_pc, memfn(m_pc)});
      else begin
        m_opc   = m_pc;
        m_instr = memfn(m_pc);
        m_ce    = 1;
      end
      m_pc = m_pc + 4;
    end else if (!stall) begin
      m_ce = 0;
    end
    if (a) mem_pend = 0;
    else if (r) begin
      mem_pend = 1;
      mem_addr = bus.f_o_imem_addr;
    end
    @(posedge f_clk);
    @(negedge f_clk);
  endtask

  initial begin
    f_rst             = 1'b1;
    f_i_stall         = 1'b0;
    f_i_flush         = 1'b0;
    f_i_change_pc     = 1'b0;
    f_i_new_pc        = '0;
    bus.f_i_imem_ack  = 1'b0;
    bus.f_i_imem_data = '0;
    m_reset();
    @(negedge f_clk);
    @(negedge f_clk);
    chk("rst_ce", 64'(f_o_ce), 64'd0);
    chk("rst_req", 64'(bus.f_o_imem_req), 64'd0);
    chk("rst_opc", 64'(f_o_pc), 64'd0);
    chk("rst_instr", 64'(f_o_instr), 64'd0);
    f_rst = 1'b0;

    // streaming with single-cycle acks
    step(0, 0, 0, 0, 1);
    chk("s_addr0", 64'(bus.f_o_imem_addr), 64'h0);
    step(0, 0, 0, 0, 1);
    chk("s_ce", 64'(f_o_ce), 64'd1);
    chk("s_addr4", 64'(bus.f_o_imem_addr), 64'h4);
    step(0, 0, 0, 0, 1);
    chk("s_opc4", 64'(f_o_pc), 64'h4);

    // stall coinciding with ack for 0x8
    step(1, 0, 0, 0, 1);
    chk("h_opc", 64'(f_o_pc), 64'h4);
    chk("h_req", 64'(bus.f_o_imem_req), 64'd0);
    step(1, 0, 0, 0, 1);
    chk("h_opc2", 64'(f_o_pc), 64'h4);
    step(0, 0, 0, 0, 1);
    chk("h_rel_opc", 64'(f_o_pc), 64'h8);
    chk("h_rel_ce", 64'(f_o_ce), 64'd1);
    chk("h_rel_addr", 64'(bus.f_o_imem_addr), 64'hC);

    // redirect with no ack: drop the late ack
    step(0, 0, 1, 32'h103, 0);
    chk("r_ce", 64'(f_o_ce), 64'd0);
    chk("r_req", 64'(bus.f_o_imem_req), 64'd0);
    step(0, 0, 0, 0, 1);
    chk("r_addr", 64'(bus.f_o_imem_addr), 64'h100);
    chk("r_req2", 64'(bus.f_o_imem_req), 64'd1);
    chk("r_ce2", 64'(f_o_ce), 64'd0);

    // flush while stalled and valid
    step(0, 0, 0, 0, 1);
    chk("f_ce1", 64'(f_o_ce), 64'd1);
    step(1, 1, 0, 0, 0);
    chk("f_ce", 64'(f_o_ce), 64'd0);
    chk("f_opc", 64'(f_o_pc), 64'h100);
    chk("f_addr", 64'(bus.f_o_imem_addr), 64'h104);

    // PC wrap at top of address space
    step(0, 0, 1, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0, 1);
    chk("w_addr", 64'(bus.f_o_imem_addr), 64'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    chk("w_wrap", 64'(bus.f_o_imem_addr), 64'h0);
    chk("w_opc", 64'(f_o_pc), 64'hFFFF_FFFC);

    // asynchronous reset mid-request
    f_rst = 1'b1;
    bus.f_i_imem_ack = 1'b0;
    #1;
    chk("ar_ce", 64'(f_o_ce), 64'd0);
    chk("ar_req", 64'(bus.f_o_imem_req), 64'd0);
    chk("ar_opc", 64'(f_o_pc), 64'd0);
    m_reset();
    @(posedge f_clk);
    @(negedge f_clk);
    f_rst = 1'b0;
    step(0, 0, 0, 0, 1);
    chk("ar_addr", 64'(bus.f_o_imem_addr), 64'(RPC));

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit          st;
      bit          fl;
      bit          cp;
      logic [31:0] np;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 19) == 0);
      cp = ($urandom_range(0, 15) == 0);
      np = ($urandom_range(0, 1) == 0) ? $urandom
         : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      step(st, fl, cp, np, $urandom_range(0, 3) != 0);
    end
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
